lab5_ram_arbiter: RTL and testbench
===================================

Name: lab5_ram_arbiter

Overview:
Two-requester arbiter for the single-port, 1-cycle-read-latency data RAM used by the Lab 5 datapath. Requester 0 is the Lab 5 execute controller (read-modify-write of RAM words). Requester 1 is the host loader, which fills and inspects RAM. Provides round-robin fairness, an atomic lock for read-modify-write sequences, and routes read data back to the issuing requester.

Parameters:
ADDR_WIDTH, 8, RAM word address width
DATA_WIDTH, 32, RAM word width
LOCK_MAX, 16, maximum consecutive cycles a lock may be held before it is forcibly released (range 2..255)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req0_valid  in  1  requester 0 has a transfer pending
req0_ready  out  1  requester 0 transfer accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_lock  in  1  hold the grant after this transfer
req0_addr  in  ADDR_WIDTH  word address
req0_wdata  in  DATA_WIDTH  write data
rsp0_valid  out  1  read data for requester 0 valid this cycle
req1_valid, req1_ready, req1_we, req1_lock, req1_addr, req1_wdata, rsp1_valid: same as requester 0, for requester 1
rsp_rdata  out  DATA_WIDTH  read data, shared by both requesters, qualified by rsp0_valid / rsp1_valid
ram_addr  out  ADDR_WIDTH  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after the address is presented
lock_timeout  out  1  one-cycle pulse when a lock is forcibly released

Behaviour:
- State:
  - last_grant (1 bit): reset 1, so requester 0 wins the first contention.
  - locked (1 bit): reset 0.
  - lock_owner (1 bit): reset 0.
  - lock_cnt (8 bit): reset 0.
  - rd_pend, rd_owner: reset 0.
- Reset values of outputs: all outputs 0. Reset is asynchronous; any pending read response is dropped and no rsp*_valid is issued after reset is released.
- Grant (combinational, at most one transfer per cycle):
  - When locked=1, only lock_owner may be granted; the other requester's ready is 0 even when idle.
  - When unlocked and exactly one valid, that requester is granted.
  - When unlocked and both valid, the requester != last_grant is granted.
  - req*_ready = grant && req*_valid. A transfer occurs when valid && ready.
  - last_grant updates to the granted index on every transfer.
- RAM drive:
  - On a transfer, ram_addr and ram_wdata come from the granted requester; ram_we = transfer && we.
  - With no transfer: ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Read response:
  - A read transfer in cycle N produces rsp<owner>_valid = 1 with rsp_rdata = ram_rdata in cycle N+1, for exactly one cycle. There is no response backpressure.
  - rsp_rdata = 0 when neither rsp valid is asserted.
  - Writes produce no response.
  - Back-to-back reads, including from alternating requesters, yield responses in consecutive cycles with the correct owners.
- Lock:
  - A transfer with lock=1 sets locked=1 and lock_owner = granting index, and clears lock_cnt.
  - An owner transfer with lock=0 clears locked at the next edge. That transfer itself is still performed.
  - While locked, lock_cnt increments every cycle. When lock_cnt reaches LOCK_MAX-1:
    - locked clears;
    - lock_timeout pulses for 1 cycle;
    - last_grant is set to lock_owner, so the other requester wins the next contention.
  - A transfer with lock=1 from the owner while already locked does not restart lock_cnt.
- Simultaneous events: a lock release and a new request from the other requester in the same cycle → the other requester may be granted no earlier than the following cycle.
- Requester inputs may change freely when ready=0. No stability requirement is imposed on them.

Test Plan:
- Single read: reset, write req1 addr 0x05 data 0xDEADBEEF; then req0 read addr 0x05 → req0_ready=1 in cycle N, rsp0_valid=1 with rsp_rdata=0xDEADBEEF in cycle N+1, rsp1_valid=0.
- Contention: both valid every cycle for 6 cycles → grants alternate 0,1,0,1,0,1, with ram_we/addr matching each grant.
- Atomic RMW: req0 read addr 3 with lock=1, req1 continuously valid → req1_ready=0 until req0 writes addr 3 with lock=0. req1 is then granted on the next cycle.
- Lock timeout: req0 asserts lock and then idles, LOCK_MAX=16 → lock_timeout pulses 16 cycles after lock acquisition. req1_ready=1 on the following cycle.
- Reset mid-read: req0 read accepted, rst=0 asserted before the next edge → all outputs 0 immediately, no rsp0_valid after release, and the first contention grants requester 0.

Source files
------------

// File: rtl/lab5_ram_arbiter.sv
// lab5_ram_arbiter: round-robin arbiter between the Lab 5 execute controller
// (requester 0) and the host loader (requester 1) for a single-port RAM with
// one cycle of read latency. Supports an atomic lock for read-modify-write
// sequences, with a forced release after LOCK_MAX locked cycles.
module lab5_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  lock_timeout
);

  // Final lock_cnt value of a lock that is never released by its owner.
  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  logic       last_grant;
  logic       locked;
  logic       lock_owner;
  logic [7:0] lock_cnt;
  logic       rd_pend;
  logic       rd_owner;

  logic                  gnt_idx;
  logic                  xfer;
  logic                  xfer_we;
  logic                  xfer_lock;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic                  timeout_hit;

  // Pick the requester that may transfer this cycle; nothing moves in reset.
  always_comb begin
    gnt_idx = 1'b0;
    xfer    = 1'b0;
    if (!rst) begin
      xfer = 1'b0;
    end else if (locked) begin
      // The lock holder is the only candidate, even if it is idle.
      gnt_idx = lock_owner;
      xfer    = lock_owner ? req1_valid : req0_valid;
    end else if (req0_valid && req1_valid) begin
      gnt_idx = ~last_grant;
      xfer    = 1'b1;
    end else if (req0_valid || req1_valid) begin
      gnt_idx = req1_valid;
      xfer    = 1'b1;
    end
  end

  assign xfer_we    = gnt_idx ? req1_we    : req0_we;
  assign xfer_lock  = gnt_idx ? req1_lock  : req0_lock;
  assign xfer_addr  = gnt_idx ? req1_addr  : req0_addr;
  assign xfer_wdata = gnt_idx ? req1_wdata : req0_wdata;

  assign req0_ready = xfer && !gnt_idx;
  assign req1_ready = xfer &&  gnt_idx;

  // The RAM bus is driven to zero whenever no transfer happens.
  assign ram_we    = xfer && xfer_we;
  assign ram_addr  = xfer ? xfer_addr  : '0;
  assign ram_wdata = xfer ? xfer_wdata : '0;

  // Read data is routed to whoever issued the read one cycle earlier.
  assign rsp0_valid = rd_pend && !rd_owner;
  assign rsp1_valid = rd_pend &&  rd_owner;
  assign rsp_rdata  = rd_pend ? ram_rdata : '0;

  assign timeout_hit  = locked && (lock_cnt == CNT_LAST);
  assign lock_timeout = timeout_hit;

  // Arbitration history, lock bookkeeping and the read-response tracker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      locked     <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= 8'd0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pend  <= xfer && !xfer_we;
      rd_owner <= gnt_idx;

      if (xfer) begin
        last_grant <= gnt_idx;
      end

      if (timeout_hit) begin
        // Forced release: hand the next contention to the other requester.
        locked     <= 1'b0;
        lock_cnt   <= 8'd0;
        last_grant <= lock_owner;
      end else if (locked) begin
        // Any transfer while locked comes from the owner; relocking does not
        // restart the count, so the owner cannot starve the other side.
        lock_cnt <= lock_cnt + 8'd1;
        if (xfer && !xfer_lock) begin
          locked <= 1'b0;
        end
      end else if (xfer && xfer_lock) begin
        locked     <= 1'b1;
        lock_owner <= gnt_idx;
        lock_cnt   <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_lab5_ram_arbiter.sv
// tb_lab5_ram_arbiter: table vectors, hand-written lock/reset sequences and a
// randomized run against a cycle-stamp based reference model.
module tb_lab5_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LM = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid, req0_ready, req0_we, req0_lock, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we, req1_lock, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          lock_timeout;

  lab5_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] initv(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v0, we0, lk0, a0, input logic [31:0] d0,
                       input int v1, we1, lk1, a1, input logic [31:0] d1);
    req0_valid = (v0 != 0); req0_we = (we0 != 0); req0_lock = (lk0 != 0);
    req0_addr = AW'(a0); req0_wdata = d0;
    req1_valid = (v1 != 0); req1_we = (we1 != 0); req1_lock = (lk1 != 0);
    req1_addr = AW'(a1); req1_wdata = d1;
  endtask

  task automatic cmp_all(input string tag, input int r0, r1, we, addr,
                         input logic [31:0] wd, input int rs0, rs1,
                         input logic [31:0] rd, input int tmo);
    check({tag, ".ready0"}, 32'(req0_ready), 32'(r0));
    check({tag, ".ready1"}, 32'(req1_ready), 32'(r1));
    check({tag, ".ram_we"}, 32'(ram_we), 32'(we));
    check({tag, ".ram_addr"}, 32'(ram_addr), 32'(addr));
    check({tag, ".ram_wdata"}, ram_wdata, wd);
    check({tag, ".rsp0_valid"}, 32'(rsp0_valid), 32'(rs0));
    check({tag, ".rsp1_valid"}, 32'(rsp1_valid), 32'(rs1));
    check({tag, ".rsp_rdata"}, rsp_rdata, rd);
    check({tag, ".lock_timeout"}, 32'(lock_timeout), 32'(tmo));
  endtask

  // ---------------- reference model ----------------
  logic [31:0] shadow [256];
  int          holder;   // -1 when no lock is held
  int          acq_cyc;  // cycle in which the current lock was taken
  int          cyc;
  int          pref;     // requester that wins the next contention
  bit          pend_v;
  int          pend_o;
  logic [31:0] pend_d;

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      mem[i]    = initv(i);
      shadow[i] = initv(i);
    end
    holder = -1; acq_cyc = 0; cyc = 0; pref = 0;
    pend_v = 1'b0; pend_o = 0; pend_d = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic rand_cycle(input int vld_pct, input int lock_pct);
    int v[2], we[2], lk[2], a[2];
    logic [31:0] d[2];
    int g;
    bit xf, tmo;
    logic [31:0] nd;
    for (int i = 0; i < 2; i++) begin
      v[i]  = ($urandom_range(0, 99) < vld_pct) ? 1 : 0;
      we[i] = $urandom_range(0, 1);
      lk[i] = ($urandom_range(0, 99) < lock_pct) ? 1 : 0;
      a[i]  = $urandom_range(0, 15);
      d[i]  = $urandom;
    end
    drive(v[0], we[0], lk[0], a[0], d[0], v[1], we[1], lk[1], a[1], d[1]);

    tmo = (holder >= 0) && (cyc - acq_cyc == LM);
    g = 0;
    xf = 1'b0;
    if (holder >= 0) begin
      g = holder; xf = (v[holder] != 0);
    end else if (v[0] != 0 && v[1] != 0) begin
      g = pref; xf = 1'b1;
    end else if (v[0] != 0 || v[1] != 0) begin
      g = (v[1] != 0) ? 1 : 0; xf = 1'b1;
    end

    @(negedge clk);
    cmp_all($sformatf("rnd%0d", cyc),
            (xf && g == 0) ? 1 : 0, (xf && g == 1) ? 1 : 0,
            (xf && we[g] != 0) ? 1 : 0, xf ? a[g] : 0, xf ? d[g] : 32'd0,
            (pend_v && pend_o == 0) ? 1 : 0, (pend_v && pend_o == 1) ? 1 : 0,
            pend_v ? pend_d : 32'd0, tmo ? 1 : 0);
    @(posedge clk);
    #1;

    nd = shadow[a[g]];
    if (xf && we[g] != 0) shadow[a[g]] = d[g];
    if (xf) pref = 1 - g;
    if (tmo) begin
      pref   = 1 - holder;
      holder = -1;
    end else if (holder >= 0) begin
      if (xf && lk[g] == 0) holder = -1;
    end else if (xf && lk[g] != 0) begin
      holder  = g;
      acq_cyc = cyc;
    end
    pend_v = xf && we[g] == 0;
    pend_o = g;
    pend_d = nd;
    cyc++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int v0, we0, a0; logic [31:0] d0;
    int v1, we1, a1; logic [31:0] d1;
    int r0, r1, ewe, eaddr; logic [31:0] ewd;
    int rs0, rs1; logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(input int v0, we0, a0, input logic [31:0] d0,
                              input int v1, we1, a1, input logic [31:0] d1,
                              input int r0, r1, ewe, eaddr, input logic [31:0] ewd,
                              input int rs0, rs1, input logic [31:0] erd);
    vec_t t;
    t.v0 = v0; t.we0 = we0; t.a0 = a0; t.d0 = d0;
    t.v1 = v1; t.we1 = we1; t.a1 = a1; t.d1 = d1;
    t.r0 = r0; t.r1 = r1; t.ewe = ewe; t.eaddr = eaddr; t.ewd = ewd;
    t.rs0 = rs0; t.rs1 = rs1; t.erd = erd;
    return t;
  endfunction

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Contention from reset: req0 writes, req1 reads, grants alternate 0,1,...
    tbl[0]  = mk(1, 1, 'h10, 'h1000, 1, 0, 'h20, 0, 1, 0, 1, 'h10, 'h1000, 0, 0, 0);
    tbl[1]  = mk(1, 1, 'h11, 'h1001, 1, 0, 'h21, 0, 0, 1, 0, 'h21, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 'h12, 'h1002, 1, 0, 'h22, 0, 1, 0, 1, 'h12, 'h1002, 0, 1, initv('h21));
    tbl[3]  = mk(1, 1, 'h13, 'h1003, 1, 0, 'h23, 0, 0, 1, 0, 'h23, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 'h14, 'h1004, 1, 0, 'h24, 0, 1, 0, 1, 'h14, 'h1004, 0, 1, initv('h23));
    tbl[5]  = mk(1, 1, 'h15, 'h1005, 1, 0, 'h25, 0, 0, 1, 0, 'h25, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, initv('h25));
    // Back-to-back reads from alternating requesters.
    tbl[7]  = mk(1, 0, 'h12, 0, 1, 0, 'h30, 0, 1, 0, 0, 'h12, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 'h12, 0, 1, 0, 'h30, 0, 0, 1, 0, 'h30, 0, 1, 0, 'h1002);
    // Single write by req1 then read-back by req0.
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 'h05, 'hDEADBEEF, 0, 1, 1, 'h05, 'hDEADBEEF, 0, 1, initv('h30));
    tbl[10] = mk(1, 0, 'h05, 0, 0, 0, 0, 0, 1, 0, 0, 'h05, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hDEADBEEF);

    // Outputs stay quiet while reset is held, even with requests pending.
    drive(1, 1, 1, 'h44, 'h1234, 1, 1, 1, 'h55, 'h5678);
    #2;
    cmp_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v0, tbl[i].we0, 0, tbl[i].a0, tbl[i].d0,
            tbl[i].v1, tbl[i].we1, 0, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      cmp_all($sformatf("tbl%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].ewe, tbl[i].eaddr,
              tbl[i].ewd, tbl[i].rs0, tbl[i].rs1, tbl[i].erd, 0);
      @(posedge clk);
      #1;
    end

    // Atomic read-modify-write: req1 is shut out until req0 drops the lock.
    do_reset();
    drive(1, 0, 1, 3, 0, 1, 1, 0, 7, 'h77);
    @(negedge clk);
    check("rmw.acq_ready0", 32'(req0_ready), 1);
    check("rmw.acq_ready1", 32'(req1_ready), 0);
    check("rmw.acq_addr", 32'(ram_addr), 3);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 1, 1, 0, 7, 'h77);
      @(negedge clk);
      check($sformatf("rmw.hold%0d_ready1", k), 32'(req1_ready), 0);
      if (k == 1) begin
        check("rmw.rsp0_valid", 32'(rsp0_valid), 1);
        check("rmw.rsp_rdata", rsp_rdata, initv(3));
      end
    end
    @(posedge clk);
    #1 drive(1, 1, 0, 3, initv(3) + 1, 1, 1, 0, 7, 'h77);
    @(negedge clk);
    check("rmw.wr_ready0", 32'(req0_ready), 1);
    check("rmw.wr_ready1", 32'(req1_ready), 0);
    check("rmw.wr_we", 32'(ram_we), 1);
    check("rmw.wr_wdata", ram_wdata, initv(3) + 1);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 1, 1, 0, 7, 'h77);
    @(negedge clk);
    check("rmw.after_ready1", 32'(req1_ready), 1);
    check("rmw.after_addr", 32'(ram_addr), 7);
    @(posedge clk);
    #1;

    // Lock timeout: req0 locks and goes idle.
    do_reset();
    drive(1, 0, 1, 9, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("tmo.acq_ready0", 32'(req0_ready), 1);
    for (int k = 1; k <= LM; k++) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 1, 1, 0, 8, 'h88);
      @(negedge clk);
      check($sformatf("tmo.c%0d_ready1", k), 32'(req1_ready), 0);
      check($sformatf("tmo.c%0d_pulse", k), 32'(lock_timeout), (k == LM) ? 1 : 0);
    end
    @(posedge clk);
    #1 drive(1, 0, 0, 2, 0, 1, 1, 0, 8, 'h88);
    @(negedge clk);
    check("tmo.next_ready1", 32'(req1_ready), 1);
    check("tmo.next_ready0", 32'(req0_ready), 0);
    check("tmo.next_pulse", 32'(lock_timeout), 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a read.
    do_reset();
    drive(1, 1, 0, 1, 'h11, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid.wr_ready0", 32'(req0_ready), 1);
    @(posedge clk);
    #1 drive(1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid.rd_ready0", 32'(req0_ready), 1);
    #1 rst = 1'b0;
    drive(1, 0, 0, 2, 0, 1, 1, 0, 4, 'h44);
    #1;
    cmp_all("mid.in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid.no_rsp0", 32'(rsp0_valid), 0);
    check("mid.no_rsp1", 32'(rsp1_valid), 0);
    check("mid.no_rdata", rsp_rdata, 0);
    @(posedge clk);
    #1 drive(1, 0, 0, 6, 0, 1, 0, 0, 7, 0);
    @(negedge clk);
    check("mid.first_ready0", 32'(req0_ready), 1);
    check("mid.first_ready1", 32'(req1_ready), 0);
    @(posedge clk);
    #1;

    // Randomized run against the reference model: busy phase, then a
    // sparse, lock-heavy phase where forced releases occur.
    do_reset();
    for (int n = 0; n < 1500; n++) rand_cycle(67, 20);
    for (int n = 0; n < 1500; n++) rand_cycle(25, 90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
